// File: rtl/dsp_drain_pkg.sv
// Shared types and widths for the DSP result drain.
// Entry = one slice result plus the mode it was produced in.
package dsp_drain_pkg;

  localparam int RES_W   = 144;
  localparam int BEAT_W  = 36;
  localparam int CHAIN_W = 44;

  typedef enum logic {
    MODE_WIDE = 1'b0,
    MODE_QUAD = 1'b1
  } drain_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

  typedef struct packed {
    drain_mode_e      mode;
    logic [RES_W-1:0] data;
  } drain_entry_t;

endpackage

// File: rtl/dsp_drain_fifo.sv
// DEPTH-entry result FIFO; head stays valid until popped.
// multi flags that more than the head is queued.
module dsp_drain_fifo
  import dsp_drain_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  drain_entry_t din,
  input  logic         pop,
  output drain_entry_t head,
  output logic         full,
  output logic         empty,
  output logic         multi
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0] C_ONE = (AW+1)'(1);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  drain_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_q;
    if (push) wr_ptr_d = wr_ptr_q + P_ONE;
    if (pop) rd_ptr_d = rd_ptr_q + P_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign head = mem_q[rd_ptr_q];
  assign full = (count_q == C_FULL);
  assign empty = (count_q == '0);
  assign multi = (count_q > C_ONE);

endmodule

// File: rtl/dsp_result_drain.sv
// Drains slice results into 36-bit beats and registers the chain value.
// DSP_DRAIN_CHAIN_SAT_EN: saturate wide chain values, add sticky sat_flag.
module dsp_result_drain
  import dsp_drain_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               res_valid,
  input  logic [RES_W-1:0]   res_data,
  input  logic               res_mode,
  output logic               res_ready,
  output logic               out_valid,
  output logic [BEAT_W-1:0]  out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [CHAIN_W-1:0] chain_out,
  output logic               chain_valid
`ifdef DSP_DRAIN_CHAIN_SAT_EN
  ,output logic              sat_flag
`endif
);

  drain_state_e state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic chain_valid_q;
  logic push, pop, full, empty, multi, last;
  drain_entry_t din, head;

  assign din = '{mode: drain_mode_e'(res_mode), data: res_data};
  assign res_ready = !full;
  assign push = res_valid && !full;

  dsp_drain_fifo #(.DEPTH(2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .multi (multi)
  );

  assign last = (beat_q == ((head.mode == MODE_QUAD) ? 2'd3 : 2'd1));

  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    pop = 1'b0;
    out_valid = 1'b0;
    out_last = 1'b0;
    out_data = '0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SEND;
          beat_d = 2'd0;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last = last;
        unique case (beat_q)
          2'd0: out_data = head.data[BEAT_W-1:0];
          2'd1: out_data = head.data[2*BEAT_W-1:BEAT_W];
          2'd2: out_data = head.data[3*BEAT_W-1:2*BEAT_W];
          2'd3: out_data = head.data[4*BEAT_W-1:3*BEAT_W];
        endcase
        if (out_ready) begin
          if (last) begin
            pop = 1'b1;
            beat_d = 2'd0;
            // A same-cycle push refills the FIFO, so keep streaming.
            state_d = (multi || push) ? SEND : IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DSP_DRAIN_CHAIN_SAT_EN
  logic sat_q, sat_d;
  logic in_range;
  assign in_range = (&res_data[71:CHAIN_W-1]) || !(|res_data[71:CHAIN_W-1]);
`endif

  always_comb begin
    chain_d = chain_q;
`ifdef DSP_DRAIN_CHAIN_SAT_EN
    sat_d = sat_q;
`endif
    if (push) begin
      if (res_mode) begin
        chain_d = {{(CHAIN_W-BEAT_W){res_data[BEAT_W-1]}}, res_data[BEAT_W-1:0]};
      end else begin
`ifdef DSP_DRAIN_CHAIN_SAT_EN
        if (in_range) begin
          chain_d = res_data[CHAIN_W-1:0];
        end else begin
          chain_d = res_data[71] ? {1'b1, {(CHAIN_W-1){1'b0}}}
                                 : {1'b0, {(CHAIN_W-1){1'b1}}};
          sat_d = 1'b1;
        end
`else
        chain_d = res_data[CHAIN_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q <= 2'd0;
      chain_q <= '0;
      chain_valid_q <= 1'b0;
`ifdef DSP_DRAIN_CHAIN_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      chain_q <= chain_d;
      chain_valid_q <= push;
`ifdef DSP_DRAIN_CHAIN_SAT_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign chain_out = chain_q;
  assign chain_valid = chain_valid_q;
`ifdef DSP_DRAIN_CHAIN_SAT_EN
  assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_dsp_result_drain.sv
// Directed bench for dsp_result_drain (both chain configurations).
module tb_dsp_result_drain;
  import dsp_drain_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic res_valid;
  logic [RES_W-1:0] res_data;
  logic res_mode;
  logic res_ready;
  logic out_valid;
  logic [BEAT_W-1:0] out_data;
  logic out_last;
  logic out_ready;
  logic [CHAIN_W-1:0] chain_out;
  logic chain_valid;
`ifdef DSP_DRAIN_CHAIN_SAT_EN
  logic sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_result_drain dut (
    .clk         (clk),
    .reset       (rst_n),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_mode    (res_mode),
    .res_ready   (res_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .chain_out   (chain_out),
    .chain_valid (chain_valid)
`ifdef DSP_DRAIN_CHAIN_SAT_EN
    ,.sat_flag   (sat_flag)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [RES_W-1:0] d);
    res_valid = v;
    res_mode = m;
    res_data = d;
  endtask

  function automatic logic [BEAT_W-1:0] beat_of(input logic [RES_W-1:0] d, input int k);
    return d[k*BEAT_W +: BEAT_W];
  endfunction

  localparam logic [RES_W-1:0] QA = {36'hA03, 36'hA02, 36'hA01, 36'hA00};
  localparam logic [RES_W-1:0] QB = {36'hB03, 36'hB02, 36'hB01, 36'hB00};
  localparam logic [RES_W-1:0] QC = {36'hC03, 36'hC02, 36'hC01, 36'hC00};
  localparam logic [RES_W-1:0] QD = {36'hD03, 36'hD02, 36'hD01, 36'hD00};
  localparam logic [RES_W-1:0] QE = {36'hE03, 36'hE02, 36'hE01, 36'hE00};

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    out_ready = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b want 0", out_last); end
    checks++; if (out_data !== 36'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (chain_out !== 44'h0) begin errors++; $display("FAIL reset_chain_out got %h want 0", chain_out); end
    checks++; if (chain_valid !== 1'b0) begin errors++; $display("FAIL reset_chain_valid got %0b want 0", chain_valid); end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready got %0b want 1", res_ready); end
`ifdef DSP_DRAIN_CHAIN_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %0b want 0", sat_flag); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_quad();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, {36'h4, 36'h3, 36'h2, 36'h1});
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL quad_res_ready got %0b want 1", res_ready); end
    tick();
    drive(1'b0, 1'b0, '0);
    checks++; if (chain_valid !== 1'b1) begin errors++; $display("FAIL quad_chain_valid got %0b want 1", chain_valid); end
    checks++; if (chain_out !== 44'h1) begin errors++; $display("FAIL quad_chain_out got %h want 1", chain_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL quad_latency1 got %0b want 0", out_valid); end
    tick();
    checks++; if (chain_valid !== 1'b0) begin errors++; $display("FAIL quad_chain_pulse got %0b want 0", chain_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL quad_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (out_data !== 36'(i + 1)) begin errors++; $display("FAIL quad_data[%0d] got %h want %h", i, out_data, 36'(i + 1)); end
      checks++; if (out_last !== (i == 3)) begin errors++; $display("FAIL quad_last[%0d] got %0b want %0b", i, out_last, (i == 3)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL quad_idle got %0b want 0", out_valid); end
  endtask

  task automatic test_wide();
    logic [BEAT_W-1:0] exp_b [2];
    exp_b[0] = 36'h5_0000_0007;
    exp_b[1] = 36'h0;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, {72'hFF, 72'h00_0000_0005_0000_0007});
    tick();
    drive(1'b0, 1'b0, '0);
    checks++; if (chain_valid !== 1'b1) begin errors++; $display("FAIL wide_chain_valid got %0b want 1", chain_valid); end
    checks++; if (chain_out !== 44'h5_0000_0007) begin errors++; $display("FAIL wide_chain_out got %h want 500000007", chain_out); end
    tick();
    checks++; if (chain_valid !== 1'b0) begin errors++; $display("FAIL wide_chain_pulse got %0b want 0", chain_valid); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wide_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (out_data !== exp_b[i]) begin errors++; $display("FAIL wide_data[%0d] got %h want %h", i, out_data, exp_b[i]); end
      checks++; if (out_last !== (i == 1)) begin errors++; $display("FAIL wide_last[%0d] got %0b want %0b", i, out_last, (i == 1)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wide_idle got %0b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, QA);
    tick();
    drive(1'b1, 1'b1, QB);
    tick();
    drive(1'b1, 1'b1, QC);
    for (int i = 0; i < 3; i++) begin
      checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL stall_full[%0d] got %0b want 0", i, res_ready); end
      checks++; if (out_data !== 36'hA00 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got %0b/%h want 1/a00", i, out_valid, out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL stall_last[%0d] got %0b want 0", i, out_last); end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== beat_of(QA, k)) begin errors++; $display("FAIL stall_a[%0d] got %h want %h", k, out_data, beat_of(QA, k)); end
      checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL stall_c_held[%0d] got %0b want 0", k, res_ready); end
      tick();
    end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL stall_c_ready got %0b want 1", res_ready); end
    checks++; if (out_data !== beat_of(QB, 0)) begin errors++; $display("FAIL stall_b[0] got %h want %h", out_data, beat_of(QB, 0)); end
    tick();
    drive(1'b0, 1'b0, '0);
    for (int k = 1; k < 8; k++) begin
      logic [BEAT_W-1:0] e;
      e = (k < 4) ? beat_of(QB, k) : beat_of(QC, k - 4);
      checks++; if (out_valid !== 1'b1 || out_data !== e) begin errors++; $display("FAIL stall_bc[%0d] got %0b/%h want 1/%h", k, out_valid, out_data, e); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, QD);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_latency got %0b want 0", out_valid); end
    drive(1'b1, 1'b1, QE);
    tick();
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      logic [BEAT_W-1:0] e;
      e = (i < 4) ? beat_of(QD, i) : beat_of(QE, i - 4);
      checks++; if (out_valid !== 1'b1 || out_data !== e) begin errors++; $display("FAIL b2b_beat[%0d] got %0b/%h want 1/%h", i, out_valid, out_data, e); end
      checks++; if (out_last !== (i == 3 || i == 7)) begin errors++; $display("FAIL b2b_last[%0d] got %0b want %0b", i, out_last, (i == 3 || i == 7)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, QA);
    tick();
    drive(1'b1, 1'b1, QB);
    tick();
    drive(1'b0, 1'b0, '0);
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL rmid_full got %0b want 0", res_ready); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_data !== beat_of(QA, k)) begin errors++; $display("FAIL rmid_beat[%0d] got %h want %h", k, out_data, beat_of(QA, k)); end
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b want 0", out_valid); end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0b want 1", res_ready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || res_ready !== 1'b1) begin errors++; $display("FAIL rmid_after[%0d] got %0b/%0b want 0/1", i, out_valid, res_ready); end
    end
  endtask

  task automatic push_wait(input logic m, input logic [RES_W-1:0] d);
    drive(1'b1, m, d);
    tick();
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_chain_sat();
    logic [CHAIN_W-1:0] e_pos, e_neg;
`ifdef DSP_DRAIN_CHAIN_SAT_EN
    e_pos = 44'h7FF_FFFF_FFFF;
    e_neg = 44'h800_0000_0000;
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_init got %0b want 0", sat_flag); end
`else
    e_pos = 44'h0;
    e_neg = 44'h0;
`endif
    out_ready = 1'b1;
    push_wait(1'b0, {72'h0, 72'h00_1000_0000_0000_0000});
    checks++; if (chain_out !== e_pos) begin errors++; $display("FAIL sat_pos got %h want %h", chain_out, e_pos); end
`ifdef DSP_DRAIN_CHAIN_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set got %0b want 1", sat_flag); end
`endif
    repeat (5) tick();
    push_wait(1'b0, {72'h0, 72'hFF_FFFF_FFFF_FFFF_FFFE});
    checks++; if (chain_out !== 44'hFFF_FFFF_FFFE) begin errors++; $display("FAIL sat_inrange got %h want fffffffffffe", chain_out); end
`ifdef DSP_DRAIN_CHAIN_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_sticky got %0b want 1", sat_flag); end
`endif
    repeat (5) tick();
    push_wait(1'b0, {72'h0, 72'hFF_F000_0000_0000_0000});
    checks++; if (chain_out !== e_neg) begin errors++; $display("FAIL sat_neg got %h want %h", chain_out, e_neg); end
    repeat (5) tick();
    push_wait(1'b1, {108'h123_4567_89AB_CDEF_0123_4567_89AB, 36'h8_0000_0001});
    checks++; if (chain_out !== 44'hFF8_0000_0001) begin errors++; $display("FAIL quad_sext got %h want ff800000001", chain_out); end
    repeat (6) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drain_idle got %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_quad();
    test_wide();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_chain_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
